// File: rtl/first_one_sequencer.sv
// first_one_sequencer: emits the set bits of an accepted vector one beat at a time, lowest first.
// Optional popcount output `remaining` enabled by macro FIRST_ONE_SEQUENCER_REMAINING_EN.
module first_one_sequencer #(
    parameter int WIDTH = 8,
    localparam int INDEX_WIDTH = $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   data_valid,
    output logic                   data_ready,
    input  logic [WIDTH-1:0]       data,
    output logic                   one_valid,
    input  logic                   one_ready,
    output logic [WIDTH-1:0]       one_hot,
    output logic [INDEX_WIDTH-1:0] one_index,
    output logic                   one_last
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] remaining
`endif
);
    typedef enum logic {IDLE, ITERATE} state_t;
    state_t                 state;
    logic [WIDTH-1:0]       pending;
    logic [WIDTH-1:0]       lowest;
    logic [INDEX_WIDTH-1:0] lowest_index;
    always_comb begin
        lowest_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--)
            if (pending[i]) lowest_index = INDEX_WIDTH'(i);
    end
    // pending is never zero in ITERATE, so these are only meaningful there
    assign lowest     = pending & (~pending + WIDTH'(1));
    assign data_ready = !reset && state == IDLE;
    assign one_valid  = !reset && state == ITERATE;
    assign one_hot    = one_valid ? lowest : '0;
    assign one_index  = one_valid ? lowest_index : '0;
    assign one_last   = one_valid && (pending & (pending - WIDTH'(1))) == '0;
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            pending <= '0;
        end else if (data_ready) begin
            if (data_valid && data != '0) begin
                pending <= data;
                state   <= ITERATE;
            end
        end else if (one_ready) begin
            pending <= pending & ~lowest;
            if (one_last) state <= IDLE;
        end
    end
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
    localparam int RW = $clog2(WIDTH + 1);
    logic [RW-1:0] count;
    always_comb begin
        count = '0;
        for (int i = 0; i < WIDTH; i++) count = count + RW'(pending[i]);
    end
    assign remaining = one_valid ? count : '0;
`endif
endmodule

// File: tb/tb_first_one_sequencer.sv
// tb_first_one_sequencer: queue-based model of pending beats checked every cycle, plus literal checks.
module tb_first_one_sequencer;
    logic       clk = 0;
    logic       reset = 1;
    logic       data_valid = 0;
    logic       data_ready;
    logic [7:0] data = 0;
    logic       one_valid;
    logic       one_ready = 0;
    logic [7:0] one_hot;
    logic [2:0] one_index;
    logic       one_last;
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
    logic [3:0] remaining;
`endif
    int tests = 0;
    int fails = 0;
    int q[$];
    int lg_idx[$];
    int lg_hot[$];
    int lg_last[$];
    int lg_rem[$];
    int low_cycles = 0;

    first_one_sequencer #(.WIDTH(8)) dut (
        .clock(clk), .reset(reset), .data_valid(data_valid), .data_ready(data_ready),
        .data(data), .one_valid(one_valid), .one_ready(one_ready), .one_hot(one_hot),
        .one_index(one_index), .one_last(one_last)
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
        , .remaining(remaining)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: the queue holds the bit indices still to be emitted, in order
    always @(posedge clk) begin
        if (reset) q.delete();
        else if (q.size() == 0) begin
            if (data_valid)
                for (int i = 0; i < 8; i++) if (data[i]) q.push_back(i);
        end else if (one_ready) void'(q.pop_front());
    end

    always @(negedge clk) begin
        bit busy;
        busy = !reset && q.size() != 0;
        chk("data_ready", data_ready, !reset && q.size() == 0);
        chk("one_valid", one_valid, busy);
        chk("one_index", one_index, busy ? q[0] : 0);
        chk("one_hot", one_hot, busy ? (1 << q[0]) : 0);
        chk("one_last", one_last, busy && q.size() == 1);
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
        chk("remaining", remaining, busy ? q.size() : 0);
`endif
        if (!reset && !data_ready) low_cycles++;
        if (one_valid && one_ready) begin
            lg_idx.push_back(one_index);
            lg_hot.push_back(one_hot);
            lg_last.push_back(one_last);
`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
            lg_rem.push_back(remaining);
`else
            lg_rem.push_back(0);
`endif
        end
    end

    task automatic clear_log();
        lg_idx.delete(); lg_hot.delete(); lg_last.delete(); lg_rem.delete();
        low_cycles = 0;
    endtask

    // mode 0: ready always, 1: toggle 1/0, 2: random
    task automatic send(input logic [7:0] v, input int mode);
        int n;
        data_valid = 1;
        data = v;
        @(posedge clk); #1;
        data_valid = 0;
        data = $urandom;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            one_ready = mode == 0 ? 1 : mode == 1 ? !n[0] : 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        one_ready = 0;
        if (n >= 200) chk("drain_timeout", n, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;

        clear_log();
        send(8'b1010_0100, 0);
        chk("a4_beats", lg_idx.size(), 3);
        chk("a4_low_cycles", low_cycles, 3);
        if (lg_idx.size() == 3) begin
            chk("a4_hot0", lg_hot[0], 8'b0000_0100); chk("a4_idx0", lg_idx[0], 2); chk("a4_last0", lg_last[0], 0);
            chk("a4_hot1", lg_hot[1], 8'b0010_0000); chk("a4_idx1", lg_idx[1], 5); chk("a4_last1", lg_last[1], 0);
            chk("a4_hot2", lg_hot[2], 8'b1000_0000); chk("a4_idx2", lg_idx[2], 7); chk("a4_last2", lg_last[2], 1);
        end
        @(negedge clk);
        chk("a4_ready_after", data_ready, 1);

        @(posedge clk); #1;
        clear_log();
        send(8'h00, 0);
        @(negedge clk);
        chk("zero_ready_next", data_ready, 1);
        chk("zero_beats", lg_idx.size(), 0);
        chk("zero_low_cycles", low_cycles, 0);

        @(posedge clk); #1;
        clear_log();
        send(8'hFF, 1);
        chk("ff_beats", lg_idx.size(), 8);
        for (int i = 0; i < 8 && i < lg_idx.size(); i++) begin
            chk("ff_idx", lg_idx[i], i);
            chk("ff_last", lg_last[i], i == 7);
        end

        @(posedge clk); #1;
        clear_log();
        data_valid = 1;
        data = 8'b0110_1001;
        one_ready = 1;
        @(posedge clk); #1;
        data_valid = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1;
        @(negedge clk);
        chk("rst_one_valid", one_valid, 0);
        chk("rst_data_ready", data_ready, 0);
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("rst_ready_after", data_ready, 1);
        repeat (5) @(posedge clk);
        #1 one_ready = 0;
        chk("rst_beats", lg_idx.size(), 2);
        if (lg_idx.size() == 2) begin
            chk("rst_idx0", lg_idx[0], 0);
            chk("rst_idx1", lg_idx[1], 3);
        end

`ifdef FIRST_ONE_SEQUENCER_REMAINING_EN
        clear_log();
        send(8'b0001_0011, 0);
        chk("rem_beats", lg_rem.size(), 3);
        if (lg_rem.size() == 3) begin
            chk("rem0", lg_rem[0], 3); chk("rem1", lg_rem[1], 2); chk("rem2", lg_rem[2], 1);
        end
        @(negedge clk);
        chk("rem_idle", remaining, 0);
        @(posedge clk); #1;
`endif

        for (int v = 0; v < 256; v++) begin
            int pc;
            clear_log();
            send(8'(v), 2);
            pc = $countones(8'(v));
            chk("sweep_count", lg_idx.size(), pc);
            for (int i = 1; i < lg_idx.size(); i++) chk("sweep_order", lg_idx[i] > lg_idx[i-1], 1);
            for (int i = 0; i < lg_idx.size(); i++) chk("sweep_hot", lg_hot[i], 1 << lg_idx[i]);
        end

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/first_one_sequencer.md
FIRST_ONE_SEQUENCER -- requirements
Module: first_one_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the input vector width (WIDTH >= 2).
REQ-002 SHALL have derived localparam INDEX_WIDTH = $clog2(WIDTH), giving the bit-index width.
REQ-003 SHALL have port clock  input  1  sole clock, rising-edge active.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_valid  input  1  input vector offered.
REQ-006 SHALL have port data_ready  output  1  sequencer can accept a vector.
REQ-007 SHALL have port data  input  WIDTH  vector whose set bits are enumerated.
REQ-008 SHALL have port one_valid  output  1  enumerated bit presented.
REQ-009 SHALL have port one_ready  input  1  consumer accepts the enumerated bit.
REQ-010 SHALL have port one_hot  output  WIDTH  one-hot mask of the current lowest set bit.
REQ-011 SHALL have port one_index  output  INDEX_WIDTH  binary index of that bit.
REQ-012 SHALL have port one_last  output  1  current bit is the final set bit of the vector.

Function
REQ-013 SHALL implement two states: IDLE and ITERATE, with an internal WIDTH-bit pending register.
REQ-014 In IDLE: data_ready = 1, one_valid = 0, one_hot = 0, one_index = 0, one_last = 0.
REQ-015 In IDLE, on data_valid & data_ready with data != 0: load data into pending and go to ITERATE on the next edge.
REQ-016 In IDLE, on data_valid & data_ready with data == 0: accept the vector, produce no output beat, and stay in IDLE.
REQ-017 In ITERATE: data_ready = 0 and one_valid = 1.
- one_hot = lowest set bit of pending; one_index = its position.
- one_last = 1 iff pending has exactly one bit set.
REQ-018 In ITERATE, on one_valid & one_ready: clear that bit in pending; if one_last, go to IDLE.
REQ-019 While one_valid = 1 and one_ready = 0, one_hot, one_index and one_last SHALL hold stable.
REQ-020 Beats SHALL be emitted in ascending bit order; the beat count equals popcount(data).
REQ-021 Latency: the first beat is valid the cycle after the vector is accepted.
REQ-022 Throughput: one beat per cycle while one_ready = 1; data_ready reasserts the cycle after the last handshake.
REQ-023 Outputs SHALL be derived from registered state only; there is no combinational path from data or data_valid to the outputs.

Reset
REQ-024 While reset = 1 at a rising edge: state = IDLE and pending = 0.
REQ-025 During any cycle with reset high: data_ready = 0 and one_valid = 0.
REQ-026 Reset asserted mid-ITERATE SHALL discard remaining bits; no further beats are produced.
REQ-027 The first cycle after reset deasserts SHALL present data_ready = 1.

Configuration
REQ-028 Macro FIRST_ONE_SEQUENCER_REMAINING_EN defined: add output port remaining  output  $clog2(WIDTH+1)  popcount(pending), which is 0 in IDLE and during reset.
REQ-029 Macro undefined: no remaining port and no popcount logic; all other behaviour is identical.

Verification (WIDTH = 8)
REQ-030 data = 8'b1010_0100 accepted, one_ready = 1 -> beats (00000100, 2, last 0), (00100000, 5, last 0), (10000000, 7, last 1); data_ready is 0 for exactly 3 cycles.
REQ-031 data = 8'h00 accepted -> one_valid is never asserted; data_ready = 1 on the next cycle.
REQ-032 data = 8'hFF, one_ready toggled 1/0 -> 8 beats with indices 0..7; outputs stable on every stalled cycle; one_last only on index 7.
REQ-033 data = 8'b0110_1001, reset pulsed after 2 beats -> one_valid = 0 during reset; data_ready = 1 the cycle after release; no stray beats afterward.
REQ-034 All 256 vectors against a model with random one_ready -> beat count = popcount, ascending order, one_hot = 1 << one_index.
REQ-035 With FIRST_ONE_SEQUENCER_REMAINING_EN, data = 8'b0001_0011 -> remaining = 3, 2, 1 on successive beats and 0 in IDLE.
